// File: rtl/booth_seq_mul.sv
// Sequential radix-2 Booth multiplier: one Booth step per cycle over WIDTH+1 steps,
// with a valid/ready operand port and a valid/ready product port.
module booth_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               signed_mode,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // valid never waits on ready, and a producer holds its data stable until the transfer.

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     q_q, q_d;
  logic [WIDTH:0]     m_q, m_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH:0]     a_op;
  logic [WIDTH:0]     a_sh;
  logic [WIDTH:0]     q_sh;
  logic [CW-1:0]      count_dec;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    qm1_d     = qm1_q;
    count_d   = count_q;
    product_d = product_q;

    // Operands carry one extra bit so -M never overflows, even for signed min.
    case ({q_q[0], qm1_q})
      2'b10:   a_op = a_q - m_q;
      2'b01:   a_op = a_q + m_q;
      default: a_op = a_q;
    endcase
    a_sh      = {a_op[WIDTH], a_op[WIDTH:1]};
    q_sh      = {a_op[0], q_q[WIDTH:1]};
    count_dec = count_q - COUNT_ONE;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          m_d     = {signed_mode & multiplicand[WIDTH-1], multiplicand};
          q_d     = {signed_mode & multiplier[WIDTH-1], multiplier};
          a_d     = '0;
          qm1_d   = 1'b0;
          count_d = COUNT_INIT;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          a_d     = a_sh;
          q_d     = q_sh;
          qm1_d   = q_q[0];
          count_d = count_dec;
          if (count_dec == '0) begin
            state_d   = S_DONE;
            product_d = {a_sh[WIDTH-2:0], q_sh};
          end
        end
      end
      S_DONE: begin
        if (out_ready || abort) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      qm1_q     <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      qm1_q     <= qm1_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign product   = product_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Bench for booth_seq_mul: directed vectors with literal products plus a per-cycle
// behavioural model (latency counter + arithmetic reference) and a product scoreboard.
module tb_booth_seq_mul;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  mcand = '0;
  logic [W-1:0]  mplier = '0;
  logic          signed_mode = 1'b0;
  logic          abort = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] product;
  logic          busy;
  logic [1:0]    dbg_state;

  booth_seq_mul #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(mcand), .multiplier(mplier), .signed_mode(signed_mode),
    .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_mul(logic [W-1:0] m, logic [W-1:0] q, logic mode);
    longint a, b;
    if (mode) begin
      a = longint'($signed(m));
      b = longint'($signed(q));
    end else begin
      a = longint'(m);
      b = longint'(q);
    end
    return PW'(a * b);
  endfunction

  // model + scoreboard
  bit            mon_en = 1'b0;
  bit            m_pend = 1'b0;
  int            m_cnt = 0;
  logic [PW-1:0] m_cur = '0;
  logic [PW-1:0] m_last = '0;
  int            n_acc = 0;
  int            n_del = 0;
  logic [PW-1:0] exp_q[$];
  bit            exp_ov;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_ov = m_pend && (m_cnt == W + 1);
      check("cyc_in_ready", in_ready, !m_pend);
      check("cyc_out_valid", out_valid, exp_ov);
      check("cyc_busy", busy, m_pend);
      check("cyc_product", product, exp_ov ? m_cur : m_last);
      if (rst) begin
        m_pend = 1'b0; m_cnt = 0; m_last = '0;
        exp_q.delete();
      end else if (!m_pend) begin
        if (in_valid) begin
          m_pend = 1'b1; m_cnt = 0;
          m_cur = ref_mul(mcand, mplier, signed_mode);
          exp_q.push_back(m_cur);
          n_acc++;
        end
      end else if (m_cnt < W + 1) begin
        if (abort) begin
          m_pend = 1'b0;
          exp_q.delete();
        end else begin
          m_cnt++;
        end
      end else if (out_ready || abort) begin
        m_pend = 1'b0;
        m_last = m_cur;
        if (out_ready) begin
          n_del++;
          check("sb_size", 64'(exp_q.size()), 1);
          if (exp_q.size() > 0) check("sb_product", product, exp_q.pop_front());
        end else begin
          exp_q.delete();
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(string name, logic [W-1:0] m, logic [W-1:0] q, logic mode,
                        logic [PW-1:0] exp);
    int lat;
    mcand = m; mplier = q; signed_mode = mode; in_valid = 1'b1;
    check({name, "_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    mcand = W'($urandom); mplier = W'($urandom); signed_mode = ~mode;
    wait_out_valid(lat);
    check({name, "_latency"}, lat, W + 1);
    check({name, "_product"}, product, exp);
    step();
  endtask

  initial begin
    int lat, a0, d0, ov_cnt;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    rst = 1'b0;

    run_op("s_m10x13",   8'hF6, 8'd13, 1'b1, 16'hFF7E);
    run_op("u255x255",   8'hFF, 8'hFF, 1'b0, 16'hFE01);
    run_op("s_m1xm1",    8'hFF, 8'hFF, 1'b1, 16'h0001);
    run_op("s_minxmin",  8'h80, 8'h80, 1'b1, 16'h4000);
    run_op("s_minxmax",  8'h80, 8'h7F, 1'b1, 16'hC080);
    run_op("u200x3",     8'd200, 8'd3, 1'b0, 16'h0258);
    run_op("s_zero",     8'h00, 8'h9C, 1'b1, 16'h0000);
    run_op("u255x1",     8'hFF, 8'h01, 1'b0, 16'h00FF);

    // backpressure with in_valid held and different operands waiting
    a0 = n_acc;
    out_ready = 1'b0;
    mcand = 8'd7; mplier = 8'd6; signed_mode = 1'b0; in_valid = 1'b1;
    step();
    mcand = 8'd9; mplier = 8'd9;
    wait_out_valid(lat);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_product", product, 16'h002A);
      step();
    end
    check("bp_one_accept", n_acc - a0, 1);
    out_ready = 1'b1; in_valid = 1'b0;
    step();
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_busy", busy, 0);

    // reset in the 4th CALC cycle
    mcand = 8'd100; mplier = 8'd100; signed_mode = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_in_ready", in_ready, 1);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_product", product, 0);
    run_op("after_rst", 8'hFD, 8'hF9, 1'b1, 16'h0015);

    // abort in the 4th CALC cycle
    d0 = n_del;
    mcand = 8'h0C; mplier = 8'h0B; signed_mode = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_in_ready", in_ready, 1);
    check("ab_busy", busy, 0);
    ov_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) ov_cnt++;
      step();
    end
    check("ab_no_valid", ov_cnt, 0);
    check("ab_no_delivery", n_del - d0, 0);

    // abort in IDLE does not block an accept
    abort = 1'b1; in_valid = 1'b1;
    mcand = 8'd5; mplier = 8'd5; signed_mode = 1'b0;
    step();
    abort = 1'b0; in_valid = 1'b0;
    check("ab_idle_busy", busy, 1);
    wait_out_valid(lat);
    check("ab_idle_product", product, 16'h0019);
    step();

    // abort together with out_ready in DONE counts as delivered
    d0 = n_del;
    mcand = 8'd3; mplier = 8'd4; signed_mode = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out_valid(lat);
    check("ab_done_product", product, 16'h000C);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_done_delivered", n_del - d0, 1);
    check("ab_done_ready", in_ready, 1);

    // back-to-back random operands, both modes
    a0 = n_acc;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20 * (W + 3); i++) begin
      mcand = W'($urandom); mplier = W'($urandom);
      signed_mode = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    check("b2b_accepts", n_acc - a0, 20);
    repeat (15) step();
    check("sb_drain", 64'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/booth_seq_mul.md
BOOTH_SEQ_MUL -- requirements
Module: booth_seq_mul

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; the block SHALL support WIDTH >= 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 in_valid  input  1  operands and mode present.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 multiplicand  input  WIDTH  operand M.
REQ-007 multiplier  input  WIDTH  operand Q.
REQ-008 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned operands.
REQ-009 abort  input  1  synchronous cancel of the operation in progress.
REQ-010 out_valid  output  1  product available.
REQ-011 out_ready  input  1  consumer accepts product.
REQ-012 product  output  2*WIDTH  result M*Q.
REQ-013 busy  output  1  high in CALC and DONE.

Function
REQ-014 FSM states SHALL be IDLE, CALC and DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-015 IDLE->CALC on in_valid&&in_ready; that edge SHALL register M, Q and signed_mode, each extended to WIDTH+1 bits (sign-extended if signed_mode=1, zero-extended otherwise), and set A=0, Q(-1)=0, count=WIDTH+1.
REQ-016 Each CALC cycle SHALL perform one radix-2 Booth step: {Q0,Q(-1)}=10 -> A=A-M; 01 -> A=A+M; 00/11 -> A unchanged; then arithmetic right shift of {A,Q,Q(-1)} by one; count decrements.
REQ-017 All add/subtract SHALL be WIDTH+1 bits wide; overflow out of A SHALL be discarded.
REQ-018 After the step at which count reaches 0, the FSM SHALL enter DONE; exactly WIDTH+1 CALC cycles, so out_valid rises WIDTH+1 cycles after the accept edge.
REQ-019 product SHALL equal the low 2*WIDTH bits of {A,Q} and SHALL be exact for all operand pairs in both modes, including signed min*min.
REQ-020 In DONE, product and out_valid SHALL be held stable while out_ready=0; DONE->IDLE on out_ready=1.
REQ-021 in_ready SHALL be 0 during CALC and DONE, so no new operands are accepted until the result is consumed; in_valid is ignored outside IDLE.
REQ-022 Input changes after the accept edge SHALL NOT affect the result.
REQ-023 abort=1 in CALC or DONE SHALL return the FSM to IDLE on the next edge with out_valid=0 and no product delivered; abort in IDLE SHALL be ignored.
REQ-024 If abort and out_ready are both 1 in DONE, the transfer SHALL be treated as accepted; the next state is IDLE either way.
REQ-025 abort=1 in IDLE together with in_valid=1 SHALL still accept the operands.
REQ-026 product SHALL retain its last value outside DONE; consumers SHALL use it only while out_valid=1.

Reset
REQ-027 rst=1 SHALL take precedence over all other inputs, including mid-CALC and in DONE.
REQ-028 On rst: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, count=0, A=Q=M=0, Q(-1)=0.
REQ-029 After rst deasserts, an operation SHALL be accepted on the first edge with in_valid=1.

Verification (WIDTH=8)
REQ-030 signed_mode=1, M=-10, Q=13, out_ready=1 -> out_valid exactly 9 cycles after accept, product=16'hFF7E (-130).
REQ-031 signed_mode=0, M=255, Q=255 -> product=16'hFE01; with signed_mode=1 the same bits (-1*-1) -> product=16'h0001.
REQ-032 signed_mode=1, M=-128, Q=-128 -> product=16'h4000; M=-128, Q=127 -> product=16'hC080.
REQ-033 Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 held -> product and out_valid stable, in_ready=0, no second accept; out_ready=1 -> IDLE, in_ready=1 on the following cycle.
REQ-034 rst=1 at the 4th CALC cycle -> next cycle IDLE, out_valid=0, product=0; a new operation then completes correctly. abort=1 at the 4th CALC cycle -> IDLE, no out_valid pulse.
REQ-035 Back-to-back operations (in_valid held, out_ready=1) with random operands in both modes -> every product matches the reference model, one result per WIDTH+3 cycles.
